// File: rtl/mult_arb_pkg.sv
// -----------------------------------------------------------------------------
// mult_arb_pkg
// Shared definitions for the two-requester multiplier front-end arbiter:
// FSM state encoding, operand/counter widths and the default WAIT timeout.
// -----------------------------------------------------------------------------
package mult_arb_pkg;

    localparam int OP_W        = 32;  // operand / product width
    localparam int CNT_W       = 8;   // WAIT-cycle counter width
    localparam int TIMEOUT_DEF = 64;  // default WAIT cycles before error

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mult_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin selector. Purely combinational.
//   req        : request vector, bit N = requester N wants service
//   last_grant : index of the requester served most recently
//   grant      : one-hot grant (all zero when nobody requests)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Sole requester wins; on contention the one not served last wins.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            if (last_grant) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
// Shares one external sequential multiplier between two requesters.
// Flow per operation: IDLE (accept) -> LOAD (mult_reset pulse) -> WAIT
// (poll mult_rdy, bounded by TIMEOUT) -> RESP (hold result until consumed).
// Ports:
//   clk, resetn                 : clock, asynchronous active-low reset
//   reqN_valid/ready/a/b        : operand request channel of requester N
//   rspN_valid/ready/p/err      : result channel of requester N
//   mult_reset, mult_a, mult_b  : load/reset and operands to the multiplier
//   mult_p, mult_rdy            : product and done flag from the multiplier
//   busy                        : an operation is in flight (not IDLE)
//   grant_id                    : owner of the current/last operation
// -----------------------------------------------------------------------------
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OP_W-1:0] req0_a,
    input  logic [OP_W-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OP_W-1:0] req1_a,
    input  logic [OP_W-1:0] req1_b,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [OP_W-1:0] rsp0_p,
    output logic            rsp0_err,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [OP_W-1:0] rsp1_p,
    output logic            rsp1_err,
    output logic            mult_reset,
    output logic [OP_W-1:0] mult_a,
    output logic [OP_W-1:0] mult_b,
    input  logic [OP_W-1:0] mult_p,
    input  logic            mult_rdy,
    output logic            busy,
    output logic            grant_id
);

    localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    // Count value seen in the last permitted WAIT cycle.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e       state_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             last_grant_r;
    logic             grant_id_r;
    // Set only once the FSM has seen a clock edge in IDLE, so no request
    // is offered ready straight out of reset.
    logic             idle_r;
    logic             mult_reset_r;
    logic             busy_r;
    logic [OP_W-1:0]  mult_a_r;
    logic [OP_W-1:0]  mult_b_r;
    logic [OP_W-1:0]  rsp_p_r;
    logic             rsp_err_r;
    logic [1:0]       rsp_valid_r;

    logic [1:0]       req_valid_s;
    logic [1:0]       arb_grant_s;
    logic [1:0]       req_ready_s;
    logic [1:0]       rsp_ready_s;
    logic             accept_s;
    logic             accept_id_s;
    logic [OP_W-1:0]  sel_a_s;
    logic [OP_W-1:0]  sel_b_s;
    logic             timeout_s;
    logic             rsp_done_s;

    assign req_valid_s = {req1_valid, req0_valid};
    assign rsp_ready_s = {rsp1_ready, rsp0_ready};

    rr_arb2 u_rr_arb2 (
        .req        (req_valid_s),
        .last_grant (last_grant_r),
        .grant      (arb_grant_s)
    );

    // Acceptance decode: ready only for the arbitration winner while idle.
    always_comb begin
        req_ready_s = 2'b00;
        if (idle_r) begin
            req_ready_s = arb_grant_s;
        end else begin
            req_ready_s = 2'b00;
        end
        accept_s    = |req_ready_s;
        accept_id_s = req_ready_s[1];
        if (accept_id_s) begin
            sel_a_s = req1_a;
            sel_b_s = req1_b;
        end else begin
            sel_a_s = req0_a;
            sel_b_s = req0_b;
        end
        timeout_s  = (wait_cnt_r == TIMEOUT_LAST);
        rsp_done_s = rsp_ready_s[grant_id_r];
    end

    // Main FSM with all registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= IDLE;
            wait_cnt_r   <= CNT_ZERO;
            last_grant_r <= 1'b1;
            grant_id_r   <= 1'b0;
            idle_r       <= 1'b0;
            mult_reset_r <= 1'b1;
            busy_r       <= 1'b0;
            mult_a_r     <= '0;
            mult_b_r     <= '0;
            rsp_p_r      <= '0;
            rsp_err_r    <= 1'b0;
            rsp_valid_r  <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r      <= LOAD;
                        mult_a_r     <= sel_a_s;
                        mult_b_r     <= sel_b_s;
                        grant_id_r   <= accept_id_s;
                        last_grant_r <= accept_id_s;
                        mult_reset_r <= 1'b1;
                        busy_r       <= 1'b1;
                        idle_r       <= 1'b0;
                        wait_cnt_r   <= CNT_ZERO;
                    end else begin
                        mult_reset_r <= 1'b0;
                        idle_r       <= 1'b1;
                    end
                end
                LOAD: begin
                    state_r      <= WAIT;
                    mult_reset_r <= 1'b0;
                    wait_cnt_r   <= CNT_ZERO;
                end
                WAIT: begin
                    // Count zero is the first WAIT cycle: any rdy there may
                    // be left over from the previous operation.
                    if ((wait_cnt_r != CNT_ZERO) && mult_rdy) begin
                        state_r     <= RESP;
                        rsp_p_r     <= mult_p;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= grant_id_r ? 2'b10 : 2'b01;
                    end else if (timeout_s) begin
                        state_r     <= RESP;
                        rsp_p_r     <= '0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= grant_id_r ? 2'b10 : 2'b01;
                    end else begin
                        wait_cnt_r  <= wait_cnt_r + CNT_ONE;
                    end
                end
                RESP: begin
                    if (rsp_done_s) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 2'b00;
                        busy_r      <= 1'b0;
                        idle_r      <= 1'b1;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    rsp_valid_r  <= 2'b00;
                    busy_r       <= 1'b0;
                    idle_r       <= 1'b0;
                    mult_reset_r <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = req_ready_s[0];
    assign req1_ready = req_ready_s[1];
    assign rsp0_valid = rsp_valid_r[0];
    assign rsp1_valid = rsp_valid_r[1];
    assign rsp0_p     = rsp_p_r;
    assign rsp1_p     = rsp_p_r;
    assign rsp0_err   = rsp_err_r;
    assign rsp1_err   = rsp_err_r;
    assign mult_reset = mult_reset_r;
    assign mult_a     = mult_a_r;
    assign mult_b     = mult_b_r;
    assign busy       = busy_r;
    assign grant_id   = grant_id_r;

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
// Directed bench for mult_arbiter with a transaction-level reference model,
// a behavioural stand-in for the sequential multiplier, and literal checks.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

    localparam int TO      = 64;
    localparam int M_DLY   = 0;
    localparam int M_NEVER = 1;
    localparam int M_STALE = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
    logic [31:0] rsp0_p, rsp1_p;
    logic        mult_reset, mult_rdy, busy, grant_id;
    logic [31:0] mult_a, mult_b, mult_p;

    mult_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_p(rsp0_p), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_p(rsp1_p), .rsp1_err(rsp1_err),
        .mult_reset(mult_reset), .mult_a(mult_a), .mult_b(mult_b),
        .mult_p(mult_p), .mult_rdy(mult_rdy),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // multiplier stand-in settings
    int mode = M_DLY;
    int dly = 2;

    // observation logs (from DUT handshakes)
    int          n_acc = 0, n_rsp = 0, rsp1_cnt = 0;
    int          acc_id_q[$];
    logic [31:0] rsp_p_q[$];
    int          last_id = 0, acc_cyc = 0, hs_cyc = 0, last_lat = 0;
    logic [31:0] last_p = 32'd0;
    logic        last_err = 1'b0;
    bit          lat_done = 1'b1;

    // reference model state
    bit          m_busy, m_resp, m_fresh, m_mrst, m_last, m_owner, m_err;
    logic [31:0] m_a, m_b, m_p;
    int          m_age;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sequential multiplier stand-in: rdy timing chosen by mode, counted in
    // cycles from the LOAD cycle (k=0).
    initial begin
        int k;
        k = 0;
        mult_rdy = 1'b0;
        mult_p = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (mult_reset && busy) k = 0;
            else if (busy) k++;
            case (mode)
                M_DLY:   mult_rdy = busy && (k >= dly);
                M_STALE: mult_rdy = busy && ((k <= 1) || (k >= 5));
                default: mult_rdy = 1'b0;
            endcase
            if (mode == M_STALE && k <= 4) mult_p = 32'hBAD0_BAD0;
            else mult_p = 32'(mult_a * mult_b);
        end
    end

    // Compare process: checks every output against the model at each
    // negedge, logs handshakes, then advances the model over the next edge.
    initial begin
        logic [1:0] v, exp_rdy, exp_rv;
        int w;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                chk("rst_ready", {req1_ready, req0_ready}, 0);
                chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
                chk("rst_rsp_p", {rsp1_p, rsp0_p}, 0);
                chk("rst_rsp_err", {rsp1_err, rsp0_err}, 0);
                chk("rst_mult_a", mult_a, 0);
                chk("rst_mult_b", mult_b, 0);
                chk("rst_busy", busy, 0);
                chk("rst_grant_id", grant_id, 0);
                chk("rst_mult_reset", mult_reset, 1);
                m_busy = 0; m_resp = 0; m_fresh = 1; m_mrst = 1; m_last = 1;
                m_owner = 0; m_err = 0; m_a = 0; m_b = 0; m_p = 0; m_age = 0;
            end else begin
                v = {req1_valid, req0_valid};
                w = -1;
                if (!m_busy && !m_fresh) begin
                    if (v == 2'b11) w = m_last ? 0 : 1;
                    else if (v[0]) w = 0;
                    else if (v[1]) w = 1;
                end
                exp_rdy = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
                exp_rv  = m_resp ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
                chk("ready", {req1_ready, req0_ready}, exp_rdy);
                chk("busy", busy, m_busy);
                chk("mult_reset", mult_reset, m_mrst);
                chk("grant_id", grant_id, m_owner);
                chk("mult_a", mult_a, m_a);
                chk("mult_b", mult_b, m_b);
                chk("rsp_valid", {rsp1_valid, rsp0_valid}, exp_rv);
                if (m_resp) begin
                    chk("rsp_p", m_owner ? rsp1_p : rsp0_p, m_p);
                    chk("rsp_err", m_owner ? rsp1_err : rsp0_err, m_err);
                end

                // handshake logs
                if (req0_valid && req0_ready) begin
                    n_acc++; acc_id_q.push_back(0); acc_cyc = cyc; lat_done = 0;
                end
                if (req1_valid && req1_ready) begin
                    n_acc++; acc_id_q.push_back(1); acc_cyc = cyc; lat_done = 0;
                end
                if (!lat_done && (rsp0_valid || rsp1_valid)) begin
                    last_lat = cyc - acc_cyc; lat_done = 1;
                end
                if (rsp1_valid) rsp1_cnt++;
                if (rsp0_valid && rsp0_ready) begin
                    n_rsp++; rsp_p_q.push_back(rsp0_p); last_id = 0;
                    last_p = rsp0_p; last_err = rsp0_err; hs_cyc = cyc;
                end
                if (rsp1_valid && rsp1_ready) begin
                    n_rsp++; rsp_p_q.push_back(rsp1_p); last_id = 1;
                    last_p = rsp1_p; last_err = rsp1_err; hs_cyc = cyc;
                end

                // model step over the coming rising edge
                if (m_fresh) begin
                    m_fresh = 0; m_mrst = 0;
                end else if (!m_busy) begin
                    if (w >= 0) begin
                        m_busy = 1; m_owner = w[0]; m_last = w[0]; m_age = 1; m_mrst = 1;
                        m_a = (w == 1) ? req1_a : req0_a;
                        m_b = (w == 1) ? req1_b : req0_b;
                    end else begin
                        m_mrst = 0;
                    end
                end else if (!m_resp) begin
                    if (m_age == 1) begin
                        m_mrst = 0; m_age = 2;
                    end else if ((m_age - 1) >= 2 && mult_rdy) begin
                        m_resp = 1; m_p = mult_p; m_err = 0;
                    end else if ((m_age - 1) == TO) begin
                        m_resp = 1; m_p = 32'd0; m_err = 1;
                    end else begin
                        m_age++;
                    end
                end else if (m_owner ? rsp1_ready : rsp0_ready) begin
                    m_resp = 0; m_busy = 0;
                end
            end
        end
    end

    task automatic wait_acc(input int target, input string name);
        int n;
        n = 0;
        while (n_acc < target && n < 400) begin
            @(negedge clk); #1; n++;
        end
        chk(name, (n_acc >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_rsp(input int target, input string name);
        int n;
        n = 0;
        while (n_rsp < target && n < 400) begin
            @(negedge clk); #1; n++;
        end
        chk(name, (n_rsp >= target) ? 1 : 0, 1);
    endtask

    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b);
        int t, r;
        t = n_acc + 1;
        r = n_rsp + 1;
        @(posedge clk); #1;
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
        wait_acc(t, "op_accept_timeout");
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(r, "op_response_timeout");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, a0, r1, cnt;
        int exp_g[4];
        logic [31:0] exp_p[4];
        exp_g = '{0, 1, 0, 1};
        exp_p = '{32'd12, 32'd25, 32'd12, 32'd25};

        resetn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_mult_reset", mult_reset, 1);
        @(negedge clk); #1;
        chk("idle_mult_reset", mult_reset, 0);

        // both requesters valid out of reset: 0,1,0,1
        rsp0_ready = 1'b1; rsp1_ready = 1'b1; mode = M_DLY; dly = 2;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4;
        req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd5;
        wait_acc(4, "rr_accept_timeout");
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(4, "rr_response_timeout");
        for (int i = 0; i < 4; i++) begin
            if (i < acc_id_q.size()) chk("rr_grant_order", acc_id_q[i], exp_g[i]);
            if (i < rsp_p_q.size())  chk("rr_product", rsp_p_q[i], exp_p[i]);
        end

        // single request, rdy 5 cycles after LOAD
        mode = M_DLY; dly = 5; r1 = rsp1_cnt;
        run_op(0, 32'd7, 32'd6);
        chk("single_p", last_p, 42);
        chk("single_err", last_err, 0);
        chk("single_id", last_id, 0);
        chk("single_latency", last_lat, 7);
        chk("single_rsp1_quiet", rsp1_cnt, r1);

        // minimum latency, product truncated to 32 bits
        dly = 2;
        run_op(1, 32'h0001_0000, 32'h0001_0003);
        chk("minlat_p", last_p, 32'h0003_0000);
        chk("minlat_latency", last_lat, 4);

        // timeout, then a normal operation
        mode = M_NEVER;
        run_op(0, 32'd2, 32'd3);
        chk("timeout_err", last_err, 1);
        chk("timeout_p", last_p, 0);
        chk("timeout_latency", last_lat, TO + 2);
        mode = M_DLY; dly = 2;
        run_op(1, 32'd6, 32'd7);
        chk("after_timeout_p", last_p, 42);
        chk("after_timeout_err", last_err, 0);

        // stale rdy through LOAD and first WAIT
        mode = M_STALE;
        run_op(0, 32'd9, 32'd11);
        chk("stale_p", last_p, 99);
        chk("stale_latency", last_lat, 7);

        // backpressure on rsp1 while req0 waits
        mode = M_DLY; dly = 2; rsp1_ready = 1'b0;
        r0 = n_rsp;
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd3;
        wait_acc(n_acc + 1, "bp_accept_timeout");
        @(posedge clk); #1;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd5;
        a0 = n_acc;
        cnt = 0;
        while (!rsp1_valid && cnt < 100) begin
            @(negedge clk); #1; cnt++;
        end
        chk("bp_rsp1_valid", rsp1_valid, 1);
        repeat (10) begin
            @(negedge clk); #1;
        end
        chk("bp_rsp1_valid_held", rsp1_valid, 1);
        chk("bp_rsp1_p_held", rsp1_p, 300);
        chk("bp_no_accept", n_acc, a0);
        @(posedge clk); #1;
        rsp1_ready = 1'b1;
        wait_acc(a0 + 1, "bp_req0_accept_timeout");
        chk("bp_accept_gap", acc_cyc - hs_cyc, 1);
        chk("bp_accept_id", acc_id_q[$], 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(r0 + 2, "bp_response_timeout");
        chk("bp_req0_p", last_p, 20);

        // reset pulse mid-WAIT
        mode = M_NEVER;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3;
        wait_acc(n_acc + 1, "rstw_accept_timeout");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        r0 = n_rsp;
        @(negedge clk); #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_mult_reset", mult_reset, 1);
        chk("rstw_rsp0_valid", rsp0_valid, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        mode = M_DLY; dly = 2;
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd3;
        a0 = n_acc;
        wait_acc(a0 + 1, "rstw_rearb_timeout");
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rstw_first_winner", acc_id_q[$], 0);
        wait_rsp(r0 + 1, "rstw_response_timeout");
        chk("rstw_p", last_p, 4);
        repeat (5) begin
            @(negedge clk); #1;
        end
        chk("rstw_no_stale_response", n_rsp, r0 + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; these are the clk and resetn ports.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the maximum WAIT cycles before an error response (range 2..255).
REQ-003 Port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-004 Port resetn, input, 1 bit: asynchronous active-low reset.
REQ-005 Port reqN_valid, input, 1 bit (N=0,1): requester N has an operand pair.
REQ-006 Port reqN_ready, output, 1 bit: the request from requester N is accepted this cycle.
REQ-007 Port reqN_a and reqN_b, inputs, 32 bits each: the operands.
REQ-008 Port rspN_valid, output, 1 bit: the result for requester N is available.
REQ-009 Port rspN_ready, input, 1 bit: requester N consumes the result.
REQ-010 Port rspN_p, output, 32 bits: the product.
REQ-011 Port rspN_err, output, 1 bit: the operation timed out.
REQ-012 Port mult_reset, output, 1 bit: active-high load/reset to seq_mult.
REQ-013 Port mult_a and mult_b, outputs, 32 bits each: operands to seq_mult.
REQ-014 Port mult_p, input, 32 bits: the seq_mult product.
REQ-015 Port mult_rdy, input, 1 bit: seq_mult done.
REQ-016 Port busy, output, 1 bit: the FSM is not in IDLE.
REQ-017 Port grant_id, output, 1 bit: the owner of the current operation.

Function
REQ-018 The FSM SHALL have four states: IDLE, LOAD, WAIT and RESP.
REQ-019 In IDLE, the block SHALL assert reqN_ready combinationally only for the arbitration winner, and only while that requester's reqN_valid is high.
  - At most one reqN_ready is high per cycle.
REQ-020 Arbitration SHALL be round-robin.
  - With a single requester valid, that requester wins.
  - With both valid, the requester not granted last wins.
  - The last-grant pointer updates only on acceptance.
REQ-021 On acceptance (valid and ready) in cycle T, the block SHALL register reqN_a/b into mult_a/b and set grant_id, then go to LOAD.
REQ-022 LOAD SHALL last exactly 1 cycle (T+1).
  - mult_reset=1; mult_a/b stable.
  - Then go to WAIT.
REQ-023 WAIT SHALL hold mult_reset=0 and mult_a/b stable.
  - mult_rdy is ignored in the first WAIT cycle (guards against stale rdy).
  - From the second WAIT cycle on, mult_rdy=1 captures mult_p and moves to RESP.
REQ-024 An 8-bit counter SHALL count WAIT cycles.
  - If the count reaches TIMEOUT without mult_rdy, go to RESP with err=1 and p=0.
  - mult_rdy arriving in the same cycle the limit is reached takes priority: err=0.
REQ-025 RESP SHALL assert rsp[grant_id]_valid with p/err held stable until rsp[grant_id]_ready=1.
  - Then return to IDLE the next cycle.
  - New requests are not accepted in the same cycle as the response handshake.
REQ-026 rspN_valid for the non-owner SHALL be 0 at all times.
REQ-027 Minimum latency SHALL be as follows:
  - acceptance at T; mult_rdy sampled at T+3 at the earliest;
  - rsp_valid at T+4 at the earliest.
REQ-028 reqN_valid dropping while not accepted SHALL have no effect; the block does not latch requests.
REQ-029 busy SHALL be 1 in LOAD, WAIT and RESP.

Reset
REQ-030 While resetn=0, the block SHALL force the following asynchronously:
  - state IDLE;
  - reqN_ready=0, rspN_valid=0, rspN_p=0, rspN_err=0;
  - mult_a=0, mult_b=0, busy=0, grant_id=0;
  - counter=0, last-grant pointer=1 (so requester 0 wins first);
  - mult_reset=1.
REQ-031 Reset asserted mid-operation SHALL discard the operation with no response.
  - After deassertion, mult_reset is 0 in IDLE.

Structure
REQ-032 A shared package mult_arb_pkg SHALL hold the following:
  - the state enum (IDLE/LOAD/WAIT/RESP);
  - the TIMEOUT default;
  - the counter width constant;
  - the operand width constant (32).
REQ-033 Two-way round-robin selection SHALL be a sub-module named rr_arb2.
  - Inputs: two requests, pointer.
  - Outputs: one-hot grant.
REQ-034 The block SHALL NOT instantiate seq_mult; the seq_mult connection is made at the peripheral level.

Verification
REQ-035 Single request: req0 a=7 b=6 with the model asserting rdy 5 cycles after LOAD -> rsp0_valid with p=42, err=0, and rsp1_valid stays 0.
REQ-036 Simultaneous requests, both valid out of reset: req0 (3×4) is granted first; then req1 (5×5) after rsp0 is consumed. Responses: rsp0 p=12, then rsp1 p=25; grant order 0,1,0,1 over 4 back-to-back pairs.
REQ-037 Timeout: the model never asserts rdy with TIMEOUT=64 -> rsp_valid after 64 WAIT cycles with err=1, p=0; the next request completes normally.
REQ-038 Stale rdy: the model holds rdy=1 through LOAD and the first WAIT cycle, then drops it and re-asserts it 3 cycles later -> the captured p is taken from the re-assertion cycle.
REQ-039 Backpressure: rsp1_ready held low for 10 cycles -> rsp1_valid and p stay stable and req0 is not accepted until the handshake.
REQ-040 Reset mid-WAIT: resetn pulsed low in WAIT -> mult_reset=1 and busy=0 immediately, no response, and req0 wins the next arbitration.
